// File: rtl/apb_master_bridge.sv
// APB master bridge: turns single-beat core requests into APB3/APB4 transfers with
// one-hot slave decode, a one-cycle response strobe and a wait-state timeout.
module apb_master_bridge #(
  parameter int SEL_LSB     = 8,
  parameter int NUM_SLV     = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        PCLK,
  input  logic        PRST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  localparam int            CW        = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LIM   = CW'(TIMEOUT_CYC);
  localparam logic [4:0]    NUM_SLV_L = 5'(NUM_SLV);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   paddr_q, paddr_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [3:0]    pstrb_q, pstrb_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic [3:0]    idx_s;
  logic          idx_ok_s;
  logic [7:0]    sel_s;
  logic [CW-1:0] wait_inc_s;
  logic          timeout_s;

  assign idx_s      = req_addr[SEL_LSB+3:SEL_LSB];
  assign idx_ok_s   = ({1'b0, idx_s} < NUM_SLV_L);
  assign sel_s      = 8'h01 << idx_s;
  // Saturating increment so the counter never wraps when the timeout is disabled.
  assign wait_inc_s = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : (wait_cnt_q + CW'(1'b1));
  assign timeout_s  = (TIMEOUT_CYC != 0) && (wait_inc_s == CNT_LIM);

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0000_0000;
    rsp_err_d   = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    wait_cnt_d  = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          if (idx_ok_s) begin
            state_d     = ST_SETUP;
            req_ready_d = 1'b0;
            psel_d      = sel_s;
            pwrite_d    = req_write;
            paddr_d     = req_addr;
            pwdata_d    = req_write ? req_wdata : 32'h0000_0000;
            pstrb_d     = req_write ? req_strb : 4'h0;
            wait_cnt_d  = {CW{1'b0}};
          end else begin
            // Unpopulated slave index: answer with an error, no bus cycle.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          psel_d      = 8'h00;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 32'h0000_0000 : PRDATA;
          rsp_err_d   = PSLVERR;
        end else begin
          wait_cnt_d = wait_inc_s;
          if (timeout_s) begin
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
            psel_d      = 8'h00;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
        psel_d      = 8'h00;
        penable_d   = 1'b0;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
      psel_q      <= 8'h00;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      pstrb_q     <= 4'h0;
      wait_cnt_q  <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: GPIO and stub APB slave models, with a
// response scoreboard checking data, error flag and request-to-response latency.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRST_N;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  logic [31:0] gpio_in, gpio_out, gpio_dir;
  int          stub_wait, stub_cnt;
  logic        stub_err, stub_hang;

  apb_master_bridge #(.SEL_LSB(8), .NUM_SLV(8), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRST_N(PRST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave 1 = GPIO (0 in, 1 out, 2 dir); slave 2 = stub with wait/error/hang knobs.
  always_comb begin
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0000_0000;
    if (PSEL[1]) begin
      case (PADDR[3:0])
        4'h0:    PRDATA = gpio_in;
        4'h1:    PRDATA = gpio_out;
        4'h2:    PRDATA = gpio_dir;
        default: PRDATA = 32'h0000_0000;
      endcase
    end else if (PSEL[2]) begin
      PREADY  = !stub_hang && (stub_cnt >= stub_wait);
      PSLVERR = stub_err && PREADY;
      PRDATA  = 32'h5A5A_0F0F;
    end
  end

  always @(posedge PCLK) stub_cnt <= (PSEL[2] && PENABLE && !PREADY) ? stub_cnt + 1 : 0;

  always @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      gpio_out <= 32'h0;
      gpio_dir <= 32'h0;
    end else if (PSEL[1] && PENABLE && PREADY && PWRITE) begin
      for (int b = 0; b < 4; b++) begin
        if (PSTRB[b] && PADDR[3:0] == 4'h1) gpio_out[b*8 +: 8] <= PWDATA[b*8 +: 8];
        if (PSTRB[b] && PADDR[3:0] == 4'h2) gpio_dir[b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest outstanding request.
  always begin
    @(posedge PCLK);
    #2;
    if (rsp_valid) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rd);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_latency", 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] erd, input logic eerr,
                       input int elat, output int acc);
    int   n;
    exp_t e;
    n = 0;
    @(negedge PCLK);
    while (!req_ready && n < 60) begin
      @(negedge PCLK);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_strb  = s;
    @(posedge PCLK);
    #1;
    acc   = cyc;
    e.rd  = erd;
    e.err = eerr;
    e.lat = elat;
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic watch(input logic [7:0] psel_e, input int n_acc, input logic [31:0] addr_e,
                       input logic [3:0] strb_e, input logic [31:0] wd_e);
    @(negedge PCLK);
    chk("setup_psel", 32'(PSEL), 32'(psel_e));
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_ready", 32'(req_ready), 32'd0);
    chk("setup_paddr", PADDR, addr_e);
    chk("setup_pstrb", 32'(PSTRB), 32'(strb_e));
    chk("setup_pwdata", PWDATA, wd_e);
    for (int i = 0; i < n_acc; i++) begin
      @(negedge PCLK);
      chk("access_psel", 32'(PSEL), 32'(psel_e));
      chk("access_penable", 32'(PENABLE), 32'd1);
      chk("access_pstrb", 32'(PSTRB), 32'(strb_e));
      chk("access_pwdata", PWDATA, wd_e);
    end
    @(negedge PCLK);
    chk("done_psel", 32'(PSEL), 32'd0);
    chk("done_penable", 32'(PENABLE), 32'd0);
    chk("done_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, a3;
    PRST_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_strb = 4'h0; gpio_in = 32'h0;
    stub_wait = 0; stub_err = 1'b0; stub_hang = 1'b0;
    #12;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    @(negedge PCLK);
    PRST_N = 1'b1;
    @(negedge PCLK);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Full-word write to GPIO output register.
    issue(1'b1, 32'h0000_0101, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 3, a0);
    req_valid = 1'b0;
    watch(8'h02, 1, 32'h0000_0101, 4'hF, 32'hA5A5_A5A5);
    chk("gpio_out", gpio_out, 32'hA5A5_A5A5);

    // Partial-strobe write to GPIO direction register.
    issue(1'b1, 32'h0000_0102, 32'h1234_5678, 4'b0101, 32'h0, 1'b0, 3, a0);
    req_valid = 1'b0;
    watch(8'h02, 1, 32'h0000_0102, 4'b0101, 32'h1234_5678);
    chk("gpio_dir", gpio_dir, 32'h0034_0078);

    // Reads: input port, then output register back.
    gpio_in = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 1'b0, 3, a0);
    req_valid = 1'b0;
    watch(8'h02, 1, 32'h0000_0100, 4'h0, 32'h0);
    issue(1'b0, 32'h0000_0101, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 3, a0);
    req_valid = 1'b0;
    watch(8'h02, 1, 32'h0000_0101, 4'h0, 32'h0);

    // Highest populated slave index.
    issue(1'b0, 32'h0000_0700, 32'h0, 4'h0, 32'h0, 1'b0, 3, a0);
    req_valid = 1'b0;
    watch(8'h80, 1, 32'h0000_0700, 4'h0, 32'h0);

    // Wait states then slave error; wait states with clean read.
    stub_wait = 3; stub_err = 1'b1;
    issue(1'b1, 32'h0000_0204, 32'h0000_0011, 4'hF, 32'h0, 1'b1, 6, a0);
    req_valid = 1'b0;
    watch(8'h04, 4, 32'h0000_0204, 4'hF, 32'h0000_0011);
    stub_wait = 2; stub_err = 1'b0;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h5A5A_0F0F, 1'b0, 5, a0);
    req_valid = 1'b0;
    watch(8'h04, 3, 32'h0000_0200, 4'h0, 32'h0);

    // Hung slave: abort after 16 ACCESS cycles.
    stub_hang = 1'b1;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h0, 1'b1, 18, a0);
    req_valid = 1'b0;
    watch(8'h04, 16, 32'h0000_0200, 4'h0, 32'h0);
    stub_hang = 1'b0; stub_wait = 0;
    drain();

    // Decode errors: no PSEL, response on the next cycle.
    issue(1'b0, 32'h0000_0900, 32'h0, 4'h0, 32'h0, 1'b1, 1, a0);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("decerr_psel", 32'(PSEL), 32'd0);
    issue(1'b1, 32'h0000_0800, 32'h1, 4'hF, 32'h0, 1'b1, 1, a0);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("decerr8_psel", 32'(PSEL), 32'd0);
    drain();

    // req_valid held high: the response cycle also accepts the next request.
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3, a0);
    issue(1'b0, 32'h0000_0101, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 3, a1);
    issue(1'b0, 32'h0000_0900, 32'h0, 4'h0, 32'h0, 1'b1, 1, a2);
    issue(1'b0, 32'h0000_0A00, 32'h0, 4'h0, 32'h0, 1'b1, 1, a3);
    req_valid = 1'b0;
    chk("b2b_spacing_01", 32'(a1 - a0), 32'd3);
    chk("b2b_spacing_12", 32'(a2 - a1), 32'd3);
    chk("b2b_spacing_decerr", 32'(a3 - a2), 32'd1);
    drain();

    // Reset in the middle of ACCESS: bus drops at once, no response.
    stub_wait = 10;
    issue(1'b0, 32'h0000_0200, 32'h0, 4'h0, 32'h5A5A_0F0F, 1'b0, 13, a0);
    req_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2;
    PRST_N = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_psel", 32'(PSEL), 32'd0);
    chk("async_rst_penable", 32'(PENABLE), 32'd0);
    chk("async_rst_ready", 32'(req_ready), 32'd0);
    @(negedge PCLK);
    @(negedge PCLK);
    PRST_N = 1'b1;
    stub_wait = 0;
    @(negedge PCLK);
    chk("rst_release_ready", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 3, a0);
    req_valid = 1'b0;
    watch(8'h02, 1, 32'h0000_0100, 4'h0, 32'h0);
    drain();

    repeat (5) @(negedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
